cordic_seq_ctl: RTL and testbench
=================================

# cordic_seq_ctl

Single-clock sequencer for the two-phase CORDIC datapath. It accepts an operation from the host over a valid/ready handshake and drives the datapath's operand ports, input-mux select and iteration-counter controls. It runs a fixed number of micro-rotations, captures the datapath outputs into result registers, and returns them over a second valid/ready handshake. It sits between the host bus and the datapath, on the datapath's control side.

## Interface

Parameters:

- ITER, 8: number of micro-rotations per operation; legal range 1..15.

Ports:

- clka  in  1  sequencer clock; all state updates on the rising edge (the datapath samples on the falling edge).
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  host operation request.
- start_ready  out  1  the sequencer can accept a request; high only in IDLE.
- start_mode  in  1  0 selects rotation; 1 selects vectoring.
- op_a  in  8  theta for rotation, x for vectoring.
- op_b  in  8  y for vectoring; ignored for rotation.
- abort  in  1  synchronous cancel of the operation in flight.
- res_valid  out  1  the result registers hold a result.
- res_ready  in  1  the host consumes the result.
- res0  out  8  captured out_port0: x for rotation, theta for vectoring.
- res1  out  8  captured out_port1: y.
- busy  out  1  state is not IDLE.
- seq_err  out  1  sticky: counter mismatch seen at capture.
- cordic_mode  out  1  mode drive to the datapath.
- dp_in0, dp_in1  out  8  drive in_port0 and in_port1 of the datapath.
- in_mux_ctl  out  2  datapath load select.
- counter_rst, counter_hold  out  1  datapath counter controls.
- counter  in  4  datapath iteration counter.
- out_port0, out_port1  in  8  datapath outputs.

## Operation

- States: IDLE, CLR, LOAD, ITER, DONE. The state register, a 4-bit iteration count `it`, the latched mode, op_a and op_b, res0/res1 and seq_err are all reset asynchronously.
- Control outputs are decoded combinationally from the state register and the latched registers. They must never glitch relative to the falling edge of clka.
- IDLE:
  - Outputs: in_mux_ctl=01, counter_rst=1, counter_hold=0, start_ready=1.
  - On start_valid: latch start_mode, op_a and op_b, and clear seq_err.
  - Next state: CLR if the mode is 1, otherwise LOAD.
- CLR (vectoring only):
  - Outputs: in_mux_ctl=00, dp_in0=0, counter_rst=1. This zeroes theta.
  - Next state: LOAD.
- LOAD:
  - Outputs: counter_rst=1, dp_in0=op_a, dp_in1=op_b.
  - in_mux_ctl=00 for rotation, 10 for vectoring.
  - Actions: it<=1.
  - Next state: DONE if ITER==1, otherwise ITER.
- ITER:
  - Outputs: in_mux_ctl=01, counter_rst=0, counter_hold=0.
  - Each cycle: it<=it+1.
  - Next state: DONE on the edge where it==ITER-1.
- Capture: on the edge that enters DONE, res0<=out_port0 and res1<=out_port1.
  - On the same edge, seq_err is set if counter != ITER-1.
- DONE:
  - Outputs: in_mux_ctl=01, counter_hold=1, res_valid=1.
  - On res_ready: return to IDLE and drop res_valid.
  - res0/res1 are not cleared; they hold their values until the next capture.
- cordic_mode is driven from the latched mode in every state except IDLE. In IDLE it is 0.
- dp_in0/dp_in1 are 0 in IDLE, ITER and DONE.
- abort:
  - In CLR, LOAD, ITER or DONE, the next state is IDLE. No capture occurs and res_valid drops.
  - Ignored in IDLE.
  - abort wins over res_ready and over the ITER→DONE transition.
- All arithmetic stays in the datapath. The sequencer only moves values; there is no width growth.

## Timing

- Reset values: state IDLE, start_ready=1, busy=0, res_valid=0, res0=res1=0, seq_err=0, in_mux_ctl=01, counter_rst=1, counter_hold=0, cordic_mode=0, dp_in0=dp_in1=0.
- Latency from the accepting edge to the edge that raises res_valid: ITER edges for rotation, ITER+1 for vectoring.
- start_ready stays 0 from the accepting edge until the edge that leaves DONE. Back-to-back operations cost one IDLE cycle.
- res_ready is sampled only in DONE. res_valid held for N cycles keeps res0/res1 stable for those N cycles.
- Reset asserted mid-operation forces the reset values immediately, independent of clka. The datapath counter is held cleared by counter_rst=1.

## Test plan

- Rotation, ITER=8: start_valid with mode 0, op_a=0x20. Required:
  - start_ready drops for 9 cycles.
  - LOAD drives in_mux_ctl=00 and dp_in0=0x20 with counter_rst=1.
  - 7 cycles of in_mux_ctl=01 follow.
  - res_valid rises exactly 8 edges after acceptance, and res0/res1 equal the datapath model output.
- Vectoring: op_a=0x40, op_b=0x10, mode 1. Required:
  - CLR cycle with in_mux_ctl=00 and dp_in0=0.
  - LOAD with in_mux_ctl=10, dp_in0=0x40, dp_in1=0x10.
  - res_valid rises 9 edges after acceptance; res0 is theta.
- Result backpressure: hold res_ready=0 for 5 cycles. Required:
  - res_valid=1 with res0/res1 stable, counter_hold=1, start_ready=0.
  - Raising res_ready returns to IDLE on the next edge.
- Abort in ITER: raise abort when it=3. Required:
  - IDLE on the next edge, res_valid never rises, res0/res1 keep their prior values.
  - abort together with res_ready in DONE also lands in IDLE.
- Counter mismatch: the bench forces counter=5 on the capture edge with ITER=8. Required:
  - seq_err=1 and it stays 1 through DONE and IDLE.
  - seq_err clears on the next accepted start.
- Async reset mid-vectoring: drop rst_n in ITER, asynchronously to clka. Required:
  - All outputs take their reset values before the next clka edge.
  - After release, start_ready=1 and counter_rst=1.
- Edge case ITER=1: the edge after LOAD enters DONE, and seq_err stays 0 with counter=0.

Source files
------------

// File: rtl/cordic_seq_ctl.sv
// Sequencer for the two-phase CORDIC datapath: latch op, CLR/LOAD, ITER-1 micro-rotations, capture results.
// Result after ITER edges (rotation) or ITER+1 (vectoring); holds in DONE until res_ready, abort returns to IDLE.
module cordic_seq_ctl #(
    parameter int ITER = 8
) (
    input  logic       clka,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic       start_mode,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    input  logic       abort,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res0,
    output logic [7:0] res1,
    output logic       busy,
    output logic       seq_err,
    output logic       cordic_mode,
    output logic [7:0] dp_in0,
    output logic [7:0] dp_in1,
    output logic [1:0] in_mux_ctl,
    output logic       counter_rst,
    output logic       counter_hold,
    input  logic [3:0] counter,
    input  logic [7:0] out_port0,
    input  logic [7:0] out_port1
);

    localparam logic [3:0] LAST = 4'(ITER - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_ITER, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] it_q, it_d;
    logic       mode_q, mode_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] opb_q, opb_d;
    logic [7:0] res0_q, res0_d;
    logic [7:0] res1_q, res1_d;
    logic       seq_err_q, seq_err_d;
    logic       capture;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            it_q      <= 4'd0;
            mode_q    <= 1'b0;
            opa_q     <= 8'd0;
            opb_q     <= 8'd0;
            res0_q    <= 8'd0;
            res1_q    <= 8'd0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            it_q      <= it_d;
            mode_q    <= mode_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res0_q    <= res0_d;
            res1_q    <= res1_d;
            seq_err_q <= seq_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        it_d      = it_q;
        mode_d    = mode_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res0_d    = res0_q;
        res1_d    = res1_q;
        seq_err_d = seq_err_q;
        capture   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    mode_d    = start_mode;
                    opa_d     = op_a;
                    opb_d     = op_b;
                    seq_err_d = 1'b0;
                    state_d   = start_mode ? S_CLR : S_LOAD;
                end
            end
            S_CLR:  state_d = S_LOAD;
            S_LOAD: begin
                it_d    = 4'd1;
                state_d = (ITER == 1) ? S_DONE : S_ITER;
            end
            S_ITER: begin
                it_d = it_q + 4'd1;
                if (it_q == LAST) state_d = S_DONE;
            end
            S_DONE: if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // abort beats both the DONE entry and the result handshake
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
        capture = (state_d == S_DONE) && (state_q != S_DONE);
        if (capture) begin
            res0_d = out_port0;
            res1_d = out_port1;
            if (counter != LAST) seq_err_d = 1'b1;
        end
    end

    // Outputs depend only on registered state, so they settle right after the rising edge.
    always_comb begin
        start_ready  = 1'b0;
        busy         = 1'b1;
        res_valid    = 1'b0;
        in_mux_ctl   = 2'b01;
        counter_rst  = 1'b0;
        counter_hold = 1'b0;
        cordic_mode  = mode_q;
        dp_in0       = 8'd0;
        dp_in1       = 8'd0;
        case (state_q)
            S_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                counter_rst = 1'b1;
                cordic_mode = 1'b0;
            end
            S_CLR: begin
                in_mux_ctl  = 2'b00;
                counter_rst = 1'b1;
            end
            S_LOAD: begin
                in_mux_ctl  = mode_q ? 2'b10 : 2'b00;
                counter_rst = 1'b1;
                dp_in0      = opa_q;
                dp_in1      = opb_q;
            end
            S_DONE: begin
                counter_hold = 1'b1;
                res_valid    = 1'b1;
            end
            default: ;
        endcase
    end

    assign res0    = res0_q;
    assign res1    = res1_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_cordic_seq_ctl.sv
// Bench for cordic_seq_ctl: toy datapath on the falling edge, scoreboard of results, per-cycle control trace.
module tb_cordic_seq_ctl;
    localparam int P  = 8;
    localparam int PI = 0, PC = 1, PL = 2, PT = 3, PD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_valid = 0, start_mode = 0, abort = 0, res_ready = 0;
    logic [7:0] op_a = 0, op_b = 0;
    logic       start_ready, res_valid, busy, seq_err, cordic_mode, counter_rst, counter_hold;
    logic [7:0] res0, res1, dp_in0, dp_in1, out_port0, out_port1;
    logic [1:0] in_mux_ctl;
    logic [3:0] counter;

    logic [7:0] dpa = 0, dpb = 0;
    logic [3:0] dcnt = 0;
    logic       force_cnt = 0;
    assign counter   = force_cnt ? 4'd5 : dcnt;
    assign out_port0 = dpa;
    assign out_port1 = dpb;

    cordic_seq_ctl #(.ITER(P)) u0 (
        .clka(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .start_mode(start_mode), .op_a(op_a), .op_b(op_b), .abort(abort),
        .res_valid(res_valid), .res_ready(res_ready), .res0(res0), .res1(res1),
        .busy(busy), .seq_err(seq_err), .cordic_mode(cordic_mode),
        .dp_in0(dp_in0), .dp_in1(dp_in1), .in_mux_ctl(in_mux_ctl),
        .counter_rst(counter_rst), .counter_hold(counter_hold), .counter(counter),
        .out_port0(out_port0), .out_port1(out_port1)
    );

    // Toy datapath: loads on mux 00/10, mixes on 01, samples on the falling edge.
    always @(negedge clk) begin
        if (counter_rst) dcnt <= 4'd0;
        else if (!counter_hold) dcnt <= dcnt + 4'd1;
        if (!counter_hold) begin
            case (in_mux_ctl)
                2'b00: begin dpa <= dp_in0;          dpb <= dp_in1; end
                2'b10: begin dpa <= dp_in0 ^ 8'h5A;  dpb <= dp_in1; end
                2'b01: begin dpa <= dpa + dpb + {4'd0, dcnt}; dpb <= dpb ^ dpa; end
                default: ;
            endcase
        end
    end

    // Second instance with ITER=1
    logic       sv1 = 0, sm1 = 0, ab1 = 0, rr1 = 0;
    logic [7:0] a1 = 0, b1 = 0;
    logic       sr1, rv1, busy1, err1, cm1, crst1, chold1;
    logic [7:0] r0_1, r1_1, dp0_1, dp1_1, q0 = 0, q1 = 0;
    logic [1:0] mux1;
    logic [3:0] c1 = 0;

    cordic_seq_ctl #(.ITER(1)) u1 (
        .clka(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
        .start_mode(sm1), .op_a(a1), .op_b(b1), .abort(ab1),
        .res_valid(rv1), .res_ready(rr1), .res0(r0_1), .res1(r1_1),
        .busy(busy1), .seq_err(err1), .cordic_mode(cm1),
        .dp_in0(dp0_1), .dp_in1(dp1_1), .in_mux_ctl(mux1),
        .counter_rst(crst1), .counter_hold(chold1), .counter(c1),
        .out_port0(q0), .out_port1(q1)
    );

    always @(negedge clk) begin
        if (crst1) c1 <= 4'd0;
        else if (!chold1) c1 <= c1 + 4'd1;
        if (mux1 == 2'b00) begin q0 <= dp0_1; q1 <= dp1_1; end
        else if (mux1 == 2'b10) begin q0 <= dp0_1 ^ 8'h5A; q1 <= dp1_1; end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [24:0] ctl_act;
    assign ctl_act = {start_ready, res_valid, busy, in_mux_ctl, counter_rst, counter_hold,
                      cordic_mode, seq_err, dp_in0, dp_in1};

    function automatic logic [24:0] ctl_exp(int p, bit m, logic [7:0] a, logic [7:0] b, bit err);
        case (p)
            PI: return {1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, err, 8'h00, 8'h00};
            PC: return {1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, m,    err, 8'h00, 8'h00};
            PL: return {1'b0, 1'b0, 1'b1, (m ? 2'b10 : 2'b00), 1'b1, 1'b0, m, err, a, b};
            PT: return {1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, m,    err, 8'h00, 8'h00};
            default: return {1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, m, err, 8'h00, 8'h00};
        endcase
    endfunction

    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] r1;
        logic       err;
    } res_t;
    res_t       sb[$];
    logic [15:0] last_res = 16'h0;
    bit          exp_err = 0;
    string       pn[5] = '{"idle", "clr", "load", "iter", "done"};

    // Monitor: every cycle res_valid is high the held result must match the queue head.
    initial begin
        res_t cur;
        bit   have_cur;
        have_cur = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                if (!have_cur) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: res_valid=1 with no result expected at %0t", $time);
                    end else begin
                        cur = sb.pop_front();
                        have_cur = 1;
                    end
                end
                if (have_cur) begin
                    chk("sb_res0", res0, cur.r0);
                    chk("sb_res1", res1, cur.r1);
                    chk("sb_err", seq_err, cur.err);
                    if (res_ready || abort) have_cur = 0;
                end
            end
        end
    end

    // ab_it: abort while `it` equals this value (0 = none); ab_done: abort alongside res_ready.
    task automatic run_op(input bit m, input logic [7:0] a, input logic [7:0] b, input int hold,
                          input int ab_it, input bit ab_done, input bit frc);
        int         ph[$];
        logic [7:0] x, y, nx, ny;
        int         it;
        bit         hit, fin;
        if (m) ph.push_back(PC);
        ph.push_back(PL);
        repeat (P - 1) ph.push_back(PT);
        repeat (hold + 1) ph.push_back(PD);
        x = m ? (a ^ 8'h5A) : a;
        y = b;
        for (int k = 0; k < P - 1; k++) begin
            nx = x + y + 8'(k);
            ny = y ^ x;
            x = nx;
            y = ny;
        end
        if (ab_it == 0) sb.push_back('{x, y, frc});

        @(posedge clk); #1;
        start_valid = 1; start_mode = m; op_a = a; op_b = b;
        @(negedge clk);
        chk("idle_accept", ctl_act, ctl_exp(PI, 0, 0, 0, exp_err));
        @(posedge clk); #1;
        start_valid = 0; start_mode = 1'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);
        exp_err = 0;
        it = 0;
        for (int i = 0; i < ph.size(); i++) begin
            if (ph[i] == PT) it++;
            if (ph[i] == PD) begin
                exp_err = frc;
                last_res = {x, y};
            end
            hit = (ph[i] == PT) && (it == ab_it);
            fin = (ph[i] == PD) && (i == ph.size() - 1);
            abort = hit || (fin && ab_done);
            res_ready = fin;
            force_cnt = frc && (ph[i] != PD) && (i + 1 < ph.size()) && (ph[i + 1] == PD);
            @(negedge clk);
            chk(pn[ph[i]], ctl_act, ctl_exp(ph[i], m, a, b, exp_err));
            @(posedge clk); #1;
            abort = 0; res_ready = 0; force_cnt = 0;
            if (hit) break;
        end
        @(negedge clk);
        chk("idle_after", ctl_act, ctl_exp(PI, 0, 0, 0, exp_err));
        chk("res_keep", {res0, res1}, last_res);
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        start_valid = 1; start_mode = 1; op_a = 8'($urandom); op_b = 8'($urandom);
        @(posedge clk); #1; start_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        chk("rst_async_ctl", ctl_act, ctl_exp(PI, 0, 0, 0, 0));
        chk("rst_async_res", {res0, res1}, 16'h0);
        @(posedge clk); #4;
        rst_n = 1;
        exp_err = 0;
        last_res = 16'h0;
        @(negedge clk);
        chk("rst_release", ctl_act, ctl_exp(PI, 0, 0, 0, 0));
    endtask

    initial begin
        bit         m;
        logic [7:0] a, b;
        int         h, ai;
        #2;
        chk("reset_ctl", ctl_act, ctl_exp(PI, 0, 0, 0, 0));
        chk("reset_res", {res0, res1}, 16'h0);
        chk("reset_u1", {sr1, rv1, busy1, mux1, crst1, chold1, cm1, err1}, 9'b1_0_0_01_1_0_0_0);
        #10 rst_n = 1;

        run_op(0, 8'h20, 8'h00, 0, 0, 0, 0);
        run_op(1, 8'h40, 8'h10, 0, 0, 0, 0);
        run_op(0, 8'($urandom), 8'($urandom), 5, 0, 0, 0);
        run_op(1, 8'($urandom), 8'($urandom), 0, 3, 0, 0);
        run_op(0, 8'($urandom), 8'($urandom), 2, 0, 1, 0);
        run_op(0, 8'($urandom), 8'($urandom), 1, 0, 0, 1);
        run_op(1, 8'($urandom), 8'($urandom), 0, 0, 0, 0);
        reset_mid();

        repeat (24) begin
            m  = 1'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            h  = $urandom_range(0, 3);
            ai = ($urandom_range(0, 3) == 0) ? $urandom_range(1, P - 1) : 0;
            run_op(m, a, b, h, ai, ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
        end

        for (int mm = 0; mm < 2; mm++) begin
            m = 1'(mm);
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            sv1 = 1; sm1 = m; a1 = a; b1 = b;
            @(negedge clk);
            chk("u1_idle", sr1, 1'b1);
            @(posedge clk); #1;
            sv1 = 0; a1 = ~a; b1 = ~b;
            if (m) begin
                @(negedge clk);
                chk("u1_clr", {mux1, crst1, dp0_1}, {2'b00, 1'b1, 8'h00});
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk("u1_load", {mux1, crst1, dp0_1, dp1_1}, {(m ? 2'b10 : 2'b00), 1'b1, a, b});
            @(posedge clk); #1;
            rr1 = 1;
            @(negedge clk);
            chk("u1_done", {rv1, busy1, chold1, cm1, err1, r0_1, r1_1},
                {1'b1, 1'b1, 1'b1, m, 1'b0, (m ? (a ^ 8'h5A) : a), b});
            @(posedge clk); #1;
            rr1 = 0;
            @(negedge clk);
            chk("u1_idle_after", {sr1, rv1, r0_1}, {1'b1, 1'b0, (m ? (a ^ 8'h5A) : a)});
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish by %0t", $time);
        $fatal(1);
    end

endmodule
